// File: rtl/panel_pkg.sv
// Shared types and helpers for the front-panel memory loader.
package panel_pkg;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  // Segments per seven-segment digit.
  localparam int SEG_W = 7;

  // Number of hex digits needed to show a value of the given bit width.
  function automatic int nibbles(input int width);
    return (width + 3) / 4;
  endfunction

endpackage

// File: rtl/seven_seg_display.sv
// Registered hex-to-seven-segment decoder for one digit.
// Segment order is {g,f,e,d,c,b,a}, active high.
module seven_seg_display
  import panel_pkg::*;
(
  input  logic             clk,
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  logic [SEG_W-1:0] seg_d;
  logic [SEG_W-1:0] seg_q;

  // Decode the nibble into its segment pattern.
  always_comb begin
    unique case (nibble)
      4'h0:    seg_d = 7'h3F;
      4'h1:    seg_d = 7'h06;
      4'h2:    seg_d = 7'h5B;
      4'h3:    seg_d = 7'h4F;
      4'h4:    seg_d = 7'h66;
      4'h5:    seg_d = 7'h6D;
      4'h6:    seg_d = 7'h7D;
      4'h7:    seg_d = 7'h07;
      4'h8:    seg_d = 7'h7F;
      4'h9:    seg_d = 7'h6F;
      4'hA:    seg_d = 7'h77;
      4'hB:    seg_d = 7'h7C;
      4'hC:    seg_d = 7'h39;
      4'hD:    seg_d = 7'h5E;
      4'hE:    seg_d = 7'h79;
      default: seg_d = 7'h71;
    endcase
  end

  // Register the pattern to decouple the pad drivers from the decode logic.
  // NOTE: pure display pipeline stage, refreshed every cycle, so it carries no reset.
  always_ff @(posedge clk) begin
    seg_q <= seg_d;
  end

  assign seg = seg_q;

endmodule

// File: rtl/front_panel_loader.sv
// Front-panel RAM loader/monitor: switch address load, edge-triggered writes and
// address steps, read-back of the addressed word, and hex displays of address,
// read data and switch input.
// Optional feature: define AUTO_INC_EN to advance the address after every write.
module front_panel_loader
  import panel_pkg::*;
#(
  parameter int WORD_SIZE  = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                addr_data,
  input  logic                                wr_en,
  input  logic                                step,
  input  logic [WORD_SIZE-1:0]                addr_data_in,
  output logic                                busy,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic                                mem_wr,
  output logic [WORD_SIZE-1:0]                mem_wdata,
  input  logic [WORD_SIZE-1:0]                mem_rdata,
  output logic [SEG_W*nibbles(ADDR_WIDTH)-1:0] addr_display,
  output logic [SEG_W*nibbles(WORD_SIZE)-1:0]  data_display,
  output logic [SEG_W*nibbles(WORD_SIZE)-1:0]  data_in_display
);

  localparam int AD = nibbles(ADDR_WIDTH);
  localparam int DD = nibbles(WORD_SIZE);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]  data_q, data_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  wr_btn_q, step_btn_q;
  logic                  wr_req, step_req;

  // One request per press: high only in the first cycle the button reads high.
  assign wr_req   = wr_en & ~wr_btn_q;
  assign step_req = step & ~step_btn_q;

`ifdef AUTO_INC_EN
  logic wrote_q;

  // Remember that the current RD_WAIT/CAPTURE pass follows a write, not a step.
  always_ff @(posedge clk) begin
    if (rst)                               wrote_q <= 1'b0;
    else if (state_q == IDLE && wr_req)    wrote_q <= 1'b1;
    else if (state_q == CAPTURE)           wrote_q <= 1'b0;
  end
`endif

  // Next-state and datapath decisions for the loader FSM.
  // NOTE: every output of this block is given a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wdata_d  = wdata_q;
    mem_wr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        data_d = mem_rdata;
        if (wr_req) begin
          wdata_d  = addr_data_in;
          mem_wr_d = 1'b1;
          state_d  = WRITE;
        end else if (step_req) begin
          addr_d  = addr_q + ADDR_WIDTH'(1);
          state_d = RD_WAIT;
        end else if (!addr_data) begin
          addr_d = ADDR_WIDTH'(addr_data_in);
        end
      end
      WRITE:   state_d = RD_WAIT;
      RD_WAIT: state_d = CAPTURE;
      default: begin
        data_d  = mem_rdata;
`ifdef AUTO_INC_EN
        if (wrote_q) addr_d = addr_q + ADDR_WIDTH'(1);
`else
        addr_d = addr_q;
`endif
        state_d = IDLE;
      end
    endcase
  end

  // State registers; button history resets high so a held button is not an edge.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      wdata_q    <= '0;
      mem_wr_q   <= 1'b0;
      wr_btn_q   <= 1'b1;
      step_btn_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wdata_q    <= wdata_d;
      mem_wr_q   <= mem_wr_d;
      wr_btn_q   <= wr_en;
      step_btn_q <= step;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wr    = mem_wr_q;
  assign mem_wdata = wdata_q;

  // Zero-pad each value to whole nibbles so unused upper digits read 0.
  logic [4*AD-1:0] addr_pad;
  logic [4*DD-1:0] data_pad;
  logic [4*DD-1:0] din_pad;

  assign addr_pad = (4*AD)'(addr_q);
  assign data_pad = (4*DD)'(data_q);
  assign din_pad  = (4*DD)'(addr_data_in);

  for (genvar i = 0; i < AD; i++) begin : g_addr_digit
    seven_seg_display u_seg (
      .clk    (clk),
      .nibble (addr_pad[4*i +: 4]),
      .seg    (addr_display[SEG_W*i +: SEG_W])
    );
  end

  for (genvar i = 0; i < DD; i++) begin : g_data_digit
    seven_seg_display u_seg_data (
      .clk    (clk),
      .nibble (data_pad[4*i +: 4]),
      .seg    (data_display[SEG_W*i +: SEG_W])
    );
    seven_seg_display u_seg_din (
      .clk    (clk),
      .nibble (din_pad[4*i +: 4]),
      .seg    (data_in_display[SEG_W*i +: SEG_W])
    );
  end

endmodule

// File: tb/tb_front_panel_loader.sv
// Directed bench for front_panel_loader (WORD_SIZE=8, ADDR_WIDTH=8) with a
// behavioural single-port RAM of 1-cycle read latency.
module tb_front_panel_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        addr_data;
  logic        wr_en;
  logic        step;
  logic [7:0]  addr_data_in;
  logic        busy;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [13:0] addr_display;
  logic [13:0] data_display;
  logic [13:0] data_in_display;

  logic [7:0]  ram [256];
  int          wr_count = 0;
  int          passed   = 0;
  int          total    = 0;
  int          count0;
  int          count1;

  front_panel_loader #(.WORD_SIZE(8), .ADDR_WIDTH(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .addr_data       (addr_data),
    .wr_en           (wr_en),
    .step            (step),
    .addr_data_in    (addr_data_in),
    .busy            (busy),
    .mem_addr        (mem_addr),
    .mem_wr          (mem_wr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .addr_display    (addr_display),
    .data_display    (data_display),
    .data_in_display (data_in_display)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: write on strobe, registered read of the old contents.
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_wdata;
      wr_count = wr_count + 1;
    end
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic do_write(input logic [7:0] d);
    addr_data_in = d;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b1; step = 1'b0; addr_data = 1'b0; addr_data_in = 8'h00;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hC3;

    // 1: reset with write button held.
    repeat (2) tick();
    check("rst_addr",  32'(mem_addr),  32'h00);
    check("rst_wr",    32'(mem_wr),    32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_wdata", 32'(mem_wdata), 32'h00);
    rst = 1'b0;
    repeat (3) tick();
    check("held_no_write", 32'(wr_count), 32'd0);
    check("held_no_busy",  32'(busy),     32'h0);
    wr_en = 1'b0;
    tick();

    // 2: load address 0x3C, write 0xA5.
    addr_data_in = 8'h3C;
    tick();
    check("load_addr", 32'(mem_addr), 32'h3C);
    tick();
    check("addr_disp", 32'(addr_display), 32'({seg7(4'h3), seg7(4'hC)}));
    addr_data = 1'b1; addr_data_in = 8'hA5; wr_en = 1'b1;
    tick();
    check("wr_strobe", 32'(mem_wr),    32'h1);
    check("wr_addr",   32'(mem_addr),  32'h3C);
    check("wr_data",   32'(mem_wdata), 32'hA5);
    check("wr_busy",   32'(busy),      32'h1);
    tick();
    check("wr_one_cycle", 32'(mem_wr), 32'h0);
    tick();
    check("busy_rd_wait", 32'(busy), 32'h1);
    tick();
    check("idle_after_3", 32'(busy), 32'h0);
    tick();
    check("data_disp_a5", 32'(data_display),    32'({seg7(4'hA), seg7(4'h5)}));
    check("din_disp_a5",  32'(data_in_display), 32'({seg7(4'hA), seg7(4'h5)}));
    check("one_write",    32'(wr_count),        32'd1);
    check("ram_3c",       32'(ram[8'h3C]),      32'hA5);
    wr_en = 1'b0;
    tick();

    // 3: two writes starting at 0xFE.
    addr_data = 1'b0; addr_data_in = 8'hFE;
    tick();
    addr_data = 1'b1;
    do_write(8'h11);
    do_write(8'h22);
`ifdef AUTO_INC_EN
    check("ram_fe",    32'(ram[8'hFE]), 32'h11);
    check("ram_ff",    32'(ram[8'hFF]), 32'h22);
    check("addr_wrap", 32'(mem_addr),   32'h00);
`else
    check("ram_fe",    32'(ram[8'hFE]), 32'h22);
    check("ram_ff",    32'(ram[8'hFF]), 32'h3C);
    check("addr_hold", 32'(mem_addr),   32'hFE);
`endif

    // 4: step from 0xFF wraps to 0x00 and reads RAM[0].
    addr_data = 1'b0; addr_data_in = 8'hFF;
    tick();
    check("load_ff", 32'(mem_addr), 32'hFF);
    addr_data = 1'b1; step = 1'b1;
    tick();
    check("step_wrap", 32'(mem_addr), 32'h00);
    check("step_busy", 32'(busy),     32'h1);
    tick();
    tick();
    check("step_idle_after_2", 32'(busy), 32'h0);
    tick();
    check("step_data_disp", 32'(data_display), 32'({seg7(4'hC), seg7(4'h3)}));
    step = 1'b0;
    tick();

    // 5: simultaneous write/step, then a press while busy.
    count0 = wr_count;
    addr_data_in = 8'h5E; wr_en = 1'b1; step = 1'b1;
    tick();
    check("both_write_wins", 32'(mem_wr),   32'h1);
    check("both_addr",       32'(mem_addr), 32'h00);
    wr_en = 1'b0; step = 1'b0;
    tick();
    wr_en = 1'b1; step = 1'b1;
    tick();
    tick();
    repeat (3) tick();
    check("busy_press_ignored", 32'(wr_count), 32'(count0 + 1));
    check("ram_00",             32'(ram[8'h00]), 32'h5E);
    check("both_idle",          32'(busy),       32'h0);
`ifdef AUTO_INC_EN
    check("both_addr_after", 32'(mem_addr), 32'h01);
`else
    check("both_addr_after", 32'(mem_addr), 32'h00);
`endif
    wr_en = 1'b0; step = 1'b0;
    tick();

    // 6: reset asserted while in WRITE.
    addr_data = 1'b0; addr_data_in = 8'h40;
    tick();
    addr_data = 1'b1; addr_data_in = 8'h77; wr_en = 1'b1;
    tick();
    check("pre_rst_wr",   32'(mem_wr),   32'h1);
    check("pre_rst_addr", 32'(mem_addr), 32'h40);
    rst = 1'b1;
    tick();
    check("rst_mid_wr",   32'(mem_wr),   32'h0);
    check("rst_mid_busy", 32'(busy),     32'h0);
    check("rst_mid_addr", 32'(mem_addr), 32'h00);
    count1 = wr_count;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("no_replay",      32'(wr_count), 32'(count1));
    check("post_rst_wr",    32'(mem_wr),   32'h0);
    check("post_rst_busy",  32'(busy),     32'h0);
    check("post_rst_addr",  32'(mem_addr), 32'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
